// File: rtl/fetch_broadcast_unit.sv
// Shared instruction-fetch front end for an N-core array.
// One synchronous IRAM read port is arbitrated round-robin between cores. A single read is
// broadcast to every requesting core whose PC matches the leader's PC. The block also runs the
// array cycle counter and writes the final count to IRAM once every core has signalled
// end-of-program.
//
// Handshake: core_req[i] is a level that the core holds until it sees core_valid[i]. core_valid[i]
// is a one-cycle pulse meaning core_instr[i] was just updated. A core is never eligible in the
// cycle its pulse is high, so one request is never served twice.
module fetch_broadcast_unit #(
  parameter int                NUM_CORES = 4,
  parameter int                ADDR_W    = 16,
  parameter int                INSTR_W   = 24,
  parameter int                CNT_W     = 24,
  parameter logic [ADDR_W-1:0] STAT_ADDR = 16'hFFFF
) (
  input  logic                         clk,
  input  logic                         controlRST,
  input  logic [NUM_CORES-1:0]         core_req,
  input  logic [NUM_CORES*ADDR_W-1:0]  core_pc,
  input  logic [NUM_CORES-1:0]         core_endp,
  output logic [NUM_CORES*INSTR_W-1:0] core_instr,
  output logic [NUM_CORES-1:0]         core_valid,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic                         mem_wren,
  output logic [INSTR_W-1:0]           mem_wdata,
  input  logic [INSTR_W-1:0]           mem_q,
  output logic [CNT_W-1:0]             cycle_count,
  output logic                         done
);

  localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  // State is kept in a named enum register so checkers can bind to state_q directly.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_CAP  = 2'd2
  } state_t;

  state_t                       state_q, state_d;
  logic [PTR_W-1:0]             rr_ptr_q, rr_ptr_d;
  logic [NUM_CORES-1:0]         grant_q, grant_d;
  logic [NUM_CORES-1:0]         done_mask_q, done_mask_d;
  logic                         write_pending_q, write_pending_d;
  logic [CNT_W-1:0]             count_latched_q, count_latched_d;

  logic [NUM_CORES*INSTR_W-1:0] core_instr_d;
  logic [NUM_CORES-1:0]         core_valid_d;
  logic [ADDR_W-1:0]            mem_addr_d;
  logic                         mem_wren_d;
  logic [INSTR_W-1:0]           mem_wdata_d;
  logic [CNT_W-1:0]             cycle_count_d;
  logic                         done_d;

  logic [NUM_CORES-1:0]         eligible;
  logic [NUM_CORES-1:0]         match_mask;
  logic                         leader_found;
  logic [PTR_W-1:0]             leader_idx;
  logic [PTR_W-1:0]             cand_idx;
  logic [ADDR_W-1:0]            leader_pc;
  logic [ADDR_W-1:0]            pc_arr [NUM_CORES];
  logic [INSTR_W-1:0]           wdata_ext;

  // Pick the leader: first eligible core at or after rr_ptr, wrapping; gather PC-matching cores.
  always_comb begin
    eligible     = core_req & ~core_valid;
    leader_found = 1'b0;
    leader_idx   = '0;
    cand_idx     = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      pc_arr[i] = core_pc[i*ADDR_W +: ADDR_W];
    end
    for (int k = 0; k < NUM_CORES; k++) begin
      cand_idx = PTR_W'((int'(rr_ptr_q) + k) % NUM_CORES);
      if (!leader_found && eligible[cand_idx]) begin
        leader_found = 1'b1;
        leader_idx   = cand_idx;
      end
    end
    leader_pc = pc_arr[leader_idx];
    for (int i = 0; i < NUM_CORES; i++) begin
      match_mask[i] = eligible[i] && (pc_arr[i] == leader_pc);
    end
    wdata_ext             = '0;
    wdata_ext[CNT_W-1:0]  = count_latched_q;
  end

  // Next-state and next-output logic for the fetch FSM, counter and write-back tracking.
  always_comb begin
    state_d         = state_q;
    rr_ptr_d        = rr_ptr_q;
    grant_d         = grant_q;
    write_pending_d = write_pending_q;
    count_latched_d = count_latched_q;
    core_instr_d    = core_instr;
    core_valid_d    = '0;
    mem_addr_d      = mem_addr;
    mem_wren_d      = 1'b0;
    mem_wdata_d     = mem_wdata;
    done_d          = done;
    done_mask_d     = done_mask_q | core_endp;
    cycle_count_d   = (&cycle_count) ? cycle_count : cycle_count + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (write_pending_q) begin
          // The count write-back takes the port ahead of any fetch this cycle.
          mem_addr_d      = STAT_ADDR;
          mem_wdata_d     = wdata_ext;
          mem_wren_d      = 1'b1;
          write_pending_d = 1'b0;
          done_d          = 1'b1;
        end else if (leader_found) begin
          grant_d    = match_mask;
          mem_addr_d = leader_pc;
          rr_ptr_d   = (leader_idx == PTR_W'(NUM_CORES - 1)) ? '0 : leader_idx + 1'b1;
          state_d    = S_RD;
        end
      end
      S_RD: begin
        state_d = S_CAP;
      end
      S_CAP: begin
        for (int i = 0; i < NUM_CORES; i++) begin
          if (grant_q[i]) begin
            core_instr_d[i*INSTR_W +: INSTR_W] = mem_q;
          end
        end
        core_valid_d = grant_q;
        state_d      = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Latch the count only on the cycle the mask first becomes complete.
    if ((&done_mask_d) && !(&done_mask_q)) begin
      count_latched_d = cycle_count;
      write_pending_d = 1'b1;
    end
  end

  // State and output registers; reset drops any in-flight read.
  always_ff @(posedge clk) begin
    if (controlRST) begin
      state_q         <= S_IDLE;
      rr_ptr_q        <= '0;
      grant_q         <= '0;
      done_mask_q     <= '0;
      write_pending_q <= 1'b0;
      count_latched_q <= '0;
      core_instr      <= '0;
      core_valid      <= '0;
      mem_addr        <= '0;
      mem_wren        <= 1'b0;
      mem_wdata       <= '0;
      cycle_count     <= '0;
      done            <= 1'b0;
    end else begin
      state_q         <= state_d;
      rr_ptr_q        <= rr_ptr_d;
      grant_q         <= grant_d;
      done_mask_q     <= done_mask_d;
      write_pending_q <= write_pending_d;
      count_latched_q <= count_latched_d;
      core_instr      <= core_instr_d;
      core_valid      <= core_valid_d;
      mem_addr        <= mem_addr_d;
      mem_wren        <= mem_wren_d;
      mem_wdata       <= mem_wdata_d;
      cycle_count     <= cycle_count_d;
      done            <= done_d;
    end
  end

endmodule

// File: tb/tb_fetch_broadcast_unit.sv
// Directed bench for fetch_broadcast_unit: lockstep broadcast, divergent PCs, round-robin
// fairness, reset during a read, cycle-count write-back and counter saturation.
module tb_fetch_broadcast_unit;

  localparam int NC = 4;
  localparam int AW = 16;
  localparam int IW = 24;

  // Clock and reset
  logic clk = 1'b0;
  logic controlRST = 1'b1;
  always #5 clk = ~clk;

  // Main instance (CNT_W = 24)
  logic [NC-1:0]    core_req;
  logic [NC*AW-1:0] core_pc;
  logic [NC-1:0]    core_endp;
  logic [NC*IW-1:0] core_instr;
  logic [NC-1:0]    core_valid;
  logic [AW-1:0]    mem_addr;
  logic             mem_wren;
  logic [IW-1:0]    mem_wdata;
  logic [IW-1:0]    mem_q;
  logic [23:0]      cycle_count;
  logic             done;

  // Saturation instance (CNT_W = 4), fetch side idle
  logic [NC-1:0]    sat_endp;
  logic [NC*IW-1:0] sat_instr;
  logic [NC-1:0]    sat_valid;
  logic [AW-1:0]    sat_addr;
  logic             sat_wren;
  logic [IW-1:0]    sat_wdata;
  logic [3:0]       sat_count;
  logic             sat_done;

  int n_checks = 0;
  int n_errors = 0;

  fetch_broadcast_unit dut (
    .clk(clk), .controlRST(controlRST),
    .core_req(core_req), .core_pc(core_pc), .core_endp(core_endp),
    .core_instr(core_instr), .core_valid(core_valid),
    .mem_addr(mem_addr), .mem_wren(mem_wren), .mem_wdata(mem_wdata), .mem_q(mem_q),
    .cycle_count(cycle_count), .done(done)
  );

  fetch_broadcast_unit #(.CNT_W(4)) dut_sat (
    .clk(clk), .controlRST(controlRST),
    .core_req('0), .core_pc('0), .core_endp(sat_endp),
    .core_instr(sat_instr), .core_valid(sat_valid),
    .mem_addr(sat_addr), .mem_wren(sat_wren), .mem_wdata(sat_wdata), .mem_q('0),
    .cycle_count(sat_count), .done(sat_done)
  );

  // IRAM contents as a fixed table; unlisted addresses return a pattern derived from the address.
  function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
    case (a)
      16'h0010: mem_word = 24'hABCDEF;
      16'h0020: mem_word = 24'h111111;
      16'h0030: mem_word = 24'h222222;
      16'h0040: mem_word = 24'h444444;
      16'h0050: mem_word = 24'h555555;
      16'h0051: mem_word = 24'h515151;
      16'h0060: mem_word = 24'h666666;
      default:  mem_word = {8'h5A, a};
    endcase
  endfunction

  // Synchronous IRAM read: data for the address registered at one edge is sampled at the next.
  always @(posedge clk) mem_q <= mem_word(mem_addr);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    controlRST = 1'b1;
    core_req   = '0;
    core_endp  = '0;
    sat_endp   = '0;
    repeat (2) @(negedge clk);
    controlRST = 1'b0;
  endtask

  task automatic set_pc(input int i, input logic [AW-1:0] pc);
    core_pc[i*AW +: AW] = pc;
  endtask

  function automatic logic [IW-1:0] instr_of(input int i);
    instr_of = core_instr[i*IW +: IW];
  endfunction

  initial begin
    core_req = '0; core_pc = '0; core_endp = '0; sat_endp = '0;

    // Reset state
    do_reset();
    check("rst_valid", core_valid, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wren", mem_wren, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_done", done, 0);
    check("rst_count", cycle_count, 0);
    check("rst_instr", core_instr, 0);

    // 1 Lockstep: one read serves all four cores
    for (int i = 0; i < NC; i++) set_pc(i, 16'h0010);
    core_req = 4'b1111;
    step();
    check("ls_addr", mem_addr, 16'h0010);
    check("ls_valid_e0", core_valid, 0);
    step();
    check("ls_valid_e1", core_valid, 0);
    step();
    check("ls_valid", core_valid, 4'b1111);
    for (int i = 0; i < NC; i++) check("ls_instr", instr_of(i), 24'hABCDEF);
    core_req = '0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("ls_single_pulse", core_valid, 0);
    end
    check("ls_addr_hold", mem_addr, 16'h0010);

    // 2 Divergent PCs: two groups, two reads, pulses 3 cycles apart
    do_reset();
    set_pc(0, 16'h0020); set_pc(1, 16'h0020); set_pc(2, 16'h0030); set_pc(3, 16'h0030);
    core_req = 4'b1111;
    step();
    check("dv_addr0", mem_addr, 16'h0020);
    step(); step();
    check("dv_valid0", core_valid, 4'b0011);
    check("dv_instr0", instr_of(0), 24'h111111);
    check("dv_instr1", instr_of(1), 24'h111111);
    core_req = 4'b1100;
    step();
    check("dv_addr1", mem_addr, 16'h0030);
    check("dv_gap", core_valid, 0);
    step(); step();
    check("dv_valid1", core_valid, 4'b1100);
    check("dv_instr2", instr_of(2), 24'h222222);
    check("dv_instr3", instr_of(3), 24'h222222);
    check("dv_instr0_held", instr_of(0), 24'h111111);
    core_req = '0;

    // 3 Fairness: core0 re-requests immediately, core3 still gets served next
    do_reset();
    set_pc(0, 16'h0050); set_pc(3, 16'h0040);
    core_req = 4'b1001;
    step();
    check("fr_addr0", mem_addr, 16'h0050);
    step(); step();
    check("fr_valid0", core_valid, 4'b0001);
    check("fr_instr0", instr_of(0), 24'h555555);
    set_pc(0, 16'h0051);
    step();
    check("fr_addr3", mem_addr, 16'h0040);
    step(); step();
    check("fr_valid3", core_valid, 4'b1000);
    check("fr_instr3", instr_of(3), 24'h444444);
    core_req = 4'b0001;
    step();
    check("fr_addr0b", mem_addr, 16'h0051);
    step(); step();
    check("fr_valid0b", core_valid, 4'b0001);
    check("fr_instr0b", instr_of(0), 24'h515151);
    core_req = '0;
    step();
    check("fr_idle", core_valid, 0);

    // 5 Reset while a read is in flight
    do_reset();
    set_pc(0, 16'h0060);
    core_req = 4'b0001;
    step();
    check("rr_addr", mem_addr, 16'h0060);
    controlRST = 1'b1;
    step();
    check("rr_valid", core_valid, 0);
    check("rr_wren", mem_wren, 0);
    check("rr_count", cycle_count, 0);
    check("rr_addr_clr", mem_addr, 0);
    controlRST = 1'b0;
    step();
    check("rr_reissue_addr", mem_addr, 16'h0060);
    check("rr_no_pulse", core_valid, 0);
    step(); step();
    check("rr_valid_after", core_valid, 4'b0001);
    check("rr_instr", instr_of(0), 24'h666666);
    core_req = '0;

    // 4 Write-back of the final cycle count
    do_reset();
    repeat (10) step();
    check("wb_count10", cycle_count, 10);
    core_endp = 4'b0001; step(); core_endp = '0; repeat (4) step();
    core_endp = 4'b0010; step(); core_endp = '0; repeat (4) step();
    core_endp = 4'b0100; step(); core_endp = '0; repeat (4) step();
    check("wb_count25", cycle_count, 25);
    check("wb_done_early", done, 0);
    core_endp = 4'b1000;
    step();
    core_endp = '0;
    check("wb_wren_pending", mem_wren, 0);
    check("wb_done_pending", done, 0);
    step();
    check("wb_wren", mem_wren, 1);
    check("wb_addr", mem_addr, 16'hFFFF);
    check("wb_wdata", mem_wdata, 24'd25);
    check("wb_done", done, 1);
    step();
    check("wb_wren_one_cycle", mem_wren, 0);
    check("wb_done_sticky", done, 1);
    core_endp = 4'b1111;
    step();
    core_endp = '0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("wb_once", mem_wren, 0);
    end
    check("wb_done_sticky2", done, 1);

    // 6 Counter saturation with a 4-bit counter
    do_reset();
    repeat (20) step();
    check("sat_count", sat_count, 4'hF);
    check("sat_main_count", cycle_count, 20);
    sat_endp = 4'b1111;
    step();
    sat_endp = '0;
    check("sat_wren_pending", sat_wren, 0);
    step();
    check("sat_wren", sat_wren, 1);
    check("sat_addr", sat_addr, 16'hFFFF);
    check("sat_wdata", sat_wdata, 24'h00000F);
    check("sat_done", sat_done, 1);
    step();
    check("sat_count_held", sat_count, 4'hF);
    check("sat_wren_off", sat_wren, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
